// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner.
// Contents: matrix dimensions, no-key code, column reset pattern,
// scan FSM state encoding and the scan-code helper.
package keypad_pkg;

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_ROWS = 4;

    // Scan code meaning "no key"; also the reserved (row 3, col 3) position.
    localparam logic [3:0] NO_KEY    = 4'hF;

    // Active-low one-hot column drive with column 0 selected.
    localparam logic [3:0] COL_RESET = 4'hE;

    typedef enum logic [1:0] {
        ST_SETTLE  = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_PUBLISH = 2'd2
    } scan_state_e;

    // Scan code of the key at matrix position (row, col).
    function automatic logic [3:0] key_code_of(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for a 4-bit group of asynchronous keypad pins.
// Resets to all-ones, i.e. the idle level of pulled-up active-low pins.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   d     - asynchronous pin values
//   q     - synchronized values, two cycles of latency
module keypad_row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_q;
    logic [3:0] meta_d;
    logic [3:0] sync_q;
    logic [3:0] sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column at a time, samples the
// synchronized rows after a settle delay, accumulates hits over a frame of
// four columns and publishes one scan code per frame.
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   row       - keypad rows, active-low, asynchronous to clk
//   col       - keypad column drive, active-low one-hot
//   keyCode   - published scan code, 4'hF = no key, held between frames
//   frameDone - one-cycle pulse when keyCode is (re)written
// Build option: KEYPAD_GHOST_REJECT_EN publishes 4'hF when more than one key
// is seen in a frame; otherwise the first key in scan order is published.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] keyCode,
    output logic       frameDone
);

    scan_state_e      state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       hit_cnt_q, hit_cnt_d;
    logic [3:0]       found_q, found_d;
    logic [3:0]       col_q, col_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             frame_done_q, frame_done_d;

    logic [3:0]       row_s;
    logic [3:0]       code_v;

    keypad_row_sync u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (row_s)
    );

    // Scan sequencing, hit accumulation and per-frame publish.
    always_comb begin
        state_d      = state_q;
        col_idx_d    = col_idx_q;
        cnt_d        = cnt_q;
        hit_cnt_d    = hit_cnt_q;
        found_d      = found_q;
        col_d        = col_q;
        key_code_d   = key_code_q;
        frame_done_d = 1'b0;
        code_v       = NO_KEY;

        case (state_q)
            ST_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                // Rows are scanned 0..3 so the first recorded hit is the
                // lowest scan position within this column.
                for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                    if (!row_s[r]) begin
                        code_v = key_code_of(2'(r), col_idx_q);
                        if (code_v != NO_KEY) begin
                            if (hit_cnt_d == 2'd0) begin
                                found_d = code_v;
                            end
                            if (hit_cnt_d != 2'd2) begin
                                hit_cnt_d = hit_cnt_d + 2'd1;
                            end
                        end
                    end
                end

                if (col_idx_q != 2'd3) begin
                    col_idx_d = col_idx_q + 2'd1;
                    col_d     = {col_q[2:0], col_q[3]};
                    cnt_d     = '0;
                    state_d   = ST_SETTLE;
                end else begin
                    state_d   = ST_PUBLISH;
                end
            end

            ST_PUBLISH: begin
`ifdef KEYPAD_GHOST_REJECT_EN
                key_code_d = (hit_cnt_q == 2'd1) ? found_q : NO_KEY;
`else
                key_code_d = (hit_cnt_q != 2'd0) ? found_q : NO_KEY;
`endif
                frame_done_d = 1'b1;
                hit_cnt_d    = 2'd0;
                found_d      = NO_KEY;
                col_idx_d    = 2'd0;
                col_d        = COL_RESET;
                cnt_d        = '0;
                state_d      = ST_SETTLE;
            end

            default: begin
                state_d = ST_SETTLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_SETTLE;
            col_idx_q    <= 2'd0;
            cnt_q        <= '0;
            hit_cnt_q    <= 2'd0;
            found_q      <= NO_KEY;
            col_q        <= COL_RESET;
            key_code_q   <= NO_KEY;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_idx_q    <= col_idx_d;
            cnt_q        <= cnt_d;
            hit_cnt_q    <= hit_cnt_d;
            found_q      <= found_d;
            col_q        <= col_d;
            key_code_q   <= key_code_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign col       = col_q;
    assign keyCode   = key_code_q;
    assign frameDone = frame_done_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a default-parameter instance and a
// SETTLE_CYCLES=3 instance, each driven by a small key-matrix model.
module tb_keypad_scanner;

`ifdef KEYPAD_GHOST_REJECT_EN
    localparam logic [3:0] GHOST_EXP = 4'hF;
`else
    localparam logic [3:0] GHOST_EXP = 4'h0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst3;
    logic [15:0] keys, keys3;           // bit r*4+c = key at (row r, col c) held
    logic [3:0]  row, row3;
    logic [3:0]  col, col3;
    logic [3:0]  key_code, key_code3;
    logic        frame_done, frame_done3;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    keypad_scanner u_dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .keyCode   (key_code),
        .frameDone (frame_done)
    );

    keypad_scanner #(.SETTLE_CYCLES(3), .CNT_W(8)) u_dut3 (
        .clk       (clk),
        .rst       (rst3),
        .row       (row3),
        .col       (col3),
        .keyCode   (key_code3),
        .frameDone (frame_done3)
    );

    // Keypad matrix: a held key pulls its row low while its column is driven.
    always_comb begin
        row  = 4'hF;
        row3 = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c]  && !col[c])  row[r]  = 1'b0;
                if (keys3[r*4+c] && !col3[c]) row3[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for the next frameDone of the selected instance; cnt = edges waited.
    task automatic frame_wait(input bit sel, input bit col_chk, input bit hold_chk,
                              input logic [3:0] hold, output int cnt);
        logic fd;
        cnt = 0;
        fd  = 1'b0;
        while (!fd && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
            fd = sel ? frame_done3 : frame_done;
            if (!sel && col_chk) begin
                if (cnt == 17) check("col_step1", col, 4'hD);
                if (cnt == 34) check("col_step2", col, 4'hB);
                if (cnt == 51) check("col_step3", col, 4'h7);
            end
            if (!sel && hold_chk && cnt == 40) check("key_held", key_code, hold);
        end
    endtask

    initial begin
        rst   = 1'b0;
        rst3  = 1'b0;
        keys  = '0;
        keys3 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col",   col,        4'hE);
        check("rst_key",   key_code,   4'hF);
        check("rst_done",  frame_done, 1'b0);
        check("rst3_col",  col3,       4'hE);
        check("rst3_key",  key_code3,  4'hF);

        // Idle scan
        rst = 1'b1;
        frame_wait(1'b0, 1'b1, 1'b0, 4'hF, n);
        check("idle_period", n, 69);
        check("idle_key", key_code, 4'hF);
        check("idle_col_back", col, 4'hE);

        // Single key at row1/col2
        keys = 16'(1) << 6;
        frame_wait(1'b0, 1'b0, 1'b0, 4'hF, n);
        check("key6_period", n, 69);
        check("key6_code", key_code, 4'h6);
        @(posedge clk);
        #1;
        check("pulse_width", frame_done, 1'b0);

        // Release: code held through the frame, then no key
        keys = '0;
        frame_wait(1'b0, 1'b0, 1'b1, 4'h6, n);
        check("release_period", n, 68);
        check("release_code", key_code, 4'hF);

        // Two keys in different columns
        keys = (16'(1) << 0) | (16'(1) << 9);
        frame_wait(1'b0, 1'b0, 1'b0, 4'hF, n);
        check("ghost_period", n, 69);
        check("ghost_code", key_code, GHOST_EXP);

        keys = 16'(1) << 6;
        frame_wait(1'b0, 1'b0, 1'b0, 4'hF, n);
        check("key6b_code", key_code, 4'h6);

        // Reserved position row3/col3
        keys = 16'(1) << 15;
        frame_wait(1'b0, 1'b0, 1'b0, 4'hF, n);
        check("reserved_code", key_code, 4'hF);

        keys = 16'(1) << 6;
        frame_wait(1'b0, 1'b0, 1'b0, 4'hF, n);
        check("key6c_code", key_code, 4'h6);

        // Reset in the middle of a frame
        repeat (30) @(posedge clk);
        #1;
        check("pre_rst_col", col, 4'hD);
        rst = 1'b0;
        #1;
        check("midrst_col",  col,        4'hE);
        check("midrst_key",  key_code,   4'hF);
        check("midrst_done", frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        frame_wait(1'b0, 1'b0, 1'b0, 4'hF, n);
        check("post_rst_period", n, 69);
        check("post_rst_code", key_code, 4'h6);

        // Minimum settle delay instance
        keys3 = 16'(1) << 0;
        @(negedge clk);
        rst3 = 1'b1;
        frame_wait(1'b1, 1'b0, 1'b0, 4'hF, n);
        check("s3_period", n, 17);
        check("s3_code0", key_code3, 4'h0);
        keys3 = 16'(1) << 9;
        frame_wait(1'b1, 1'b0, 1'b0, 4'hF, n);
        check("s3_period2", n, 17);
        check("s3_code9", key_code3, 4'h9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the 4x4 matrix keypad columns and samples the rows.
- Produces the 4-bit scan code (4'hF = no key) consumed by the keypad key-value/debounce register downstream.
- Scans one column at a time with a settle delay, accumulates hits over a full frame, then publishes one code per frame.
- Sits between the FPGA keypad pins and the debounce register's inputValue.

Parameters:
- SETTLE_CYCLES, 16, clk cycles each column is driven before rows are sampled; legal minimum 3.
- CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES-1.

Ports:
- clk  input  1  system clock; all flops on posedge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- row  input  4  keypad rows, active-low with external pull-ups, asynchronous to clk.
- col  output  4  keypad column drive, active-low one-hot; exactly one bit is 0 at all times.
- keyCode  output  4  published scan code, 4'hF = no key; held between publishes.
- frameDone  output  1  one-cycle pulse in the cycle keyCode is (re)written.

Behaviour:
- Reset (rst=0, async):
  - col=4'hE; keyCode=4'hF; frameDone=0.
  - State SETTLE, colIdx=0, counter=0.
  - Row synchronizer = 4'hF; accumulators cleared (hitCnt=0, found=4'hF).
- Row input passes through a 2-flop synchronizer (rowS, 2-cycle latency).
- SETTLE:
  - Counter increments each cycle.
  - When counter==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (1 cycle), for each row r with rowS[r]==0:
  - Key at (r, colIdx) has code {r[1:0], colIdx[1:0]}.
  - Code 4'hF (row 3, col 3) is reserved and ignored; it does not count as a hit.
  - Each valid hit increments hitCnt, saturating at 2; found is written on the first hit only.
  - If colIdx<3: colIdx+1, col rotates left (E→D→B→7), counter=0, go to SETTLE.
  - If colIdx==3: go to PUBLISH.
- PUBLISH (1 cycle):
  - keyCode = found if hitCnt==1, else 4'hF (multi-hit handling: see Optional Feature).
  - frameDone=1 this cycle only.
  - Clear accumulators; colIdx=0, col=4'hE, counter=0; go to SETTLE.
- Frame period is exactly 4*(SETTLE_CYCLES+1)+1 cycles (69 at default). frameDone pulses at that period from reset release.
- keyCode changes only in PUBLISH. No debounce is done here; debounce is the downstream register's job.
- Row changes mid-frame: only the value present at each column's SAMPLE counts. A key released before its column is sampled is not reported.
- Multiple rows low in one column count as multiple hits.
- Reset mid-frame takes effect immediately; the partial frame is discarded with no frameDone.
- The column switches in the same cycle SAMPLE exits. The synchronizer latency is covered by SETTLE_CYCLES≥3.

Optional Feature:
- Macro KEYPAD_GHOST_REJECT_EN.
- Defined: hitCnt≥2 publishes 4'hF (ghost/multi-key rejection).
- Undefined: hitCnt saturation is unused; the first valid hit in scan order (col 0→3, row 0→3 within a column) is published, i.e. the lowest {col, row} scan position wins.

Decomposition:
- Package keypad_pkg:
  - NO_KEY=4'hF.
  - State encoding: SETTLE, SAMPLE, PUBLISH (2-bit).
  - NUM_COLS=4, NUM_ROWS=4.
  - COL_RESET=4'hE.
- Sub-module keypad_row_sync: 4-bit 2-flop synchronizer, async active-low reset to 4'hF. Reused for any asynchronous keypad pin.

Test Plan:
- No key held, default params → col cycles E,D,B,7; frameDone every 69 cycles; keyCode stays 4'hF.
- Row1 low only while col==4'hB (col2) → keyCode=4'h6 at the next PUBLISH, held until a later frame without the key returns 4'hF.
- Row0 low during col0 and row2 low during col1 → 4'hF with KEYPAD_GHOST_REJECT_EN; 4'h0 without it.
- Row3 low during col3 only → keyCode remains 4'hF (reserved position).
- Key pressed, rst asserted mid-frame at cycle 30 → col=4'hE, keyCode=4'hF, frameDone=0 immediately; first frameDone 69 cycles after release.
- SETTLE_CYCLES=3 and row0 low during col0 → keyCode=4'h0, frame period 17 cycles, no stale sample from the previous column.
